dfe_tap_loader: RTL and testbench

Sequencer that configures and gates the parallel DFE slice. Each start request runs the same sequence: reset the DFE, fetch PULSE_RESPONSE_LENGTH tap words from the on-chip coefficient memory, drive the DFE tap-load port with the exact cycle pattern the DFE needs, and wait for its done_wait. Only after that does it forward upstream samples into the DFE signal input. It sits between the coefficient memory / sample source and the DFE instance in the Rx simulation path.

---
 rtl/dfe_tap_loader.sv | 131 +++++++++++++
 tb/tb_dfe_tap_loader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfe_tap_loader.sv
// Configuration sequencer for the parallel DFE slice: resets the DFE, loads its taps
// from coefficient memory, waits for done_wait, then forwards upstream samples.
module dfe_tap_loader #(
   parameter int PULSE_RESPONSE_LENGTH = 5,
   parameter int SIGNAL_RESOLUTION     = 8,
   parameter int TIMEOUT_CYCLES        = 64
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                start,
   input  logic [7:0]                          cfg_base,
   output logic                                mem_rd_en,
   output logic [7:0]                          mem_rd_addr,
   input  logic [63:0]                         mem_rd_data,
   output logic                                dfe_rstn,
   output logic                                dfe_load_mem,
   output logic [7:0]                          dfe_location,
   output logic [63:0]                         dfe_mem_data,
   input  logic                                dfe_done_wait,
   input  logic signed [SIGNAL_RESOLUTION-1:0] up_data,
   input  logic                                up_valid,
   output logic                                up_ready,
   output logic signed [SIGNAL_RESOLUTION-1:0] dfe_signal_in,
   output logic                                dfe_signal_in_valid,
   output logic                                busy,
   output logic                                configured,
   output logic                                error
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DRST  = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_LOAD  = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_RUN   = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [8:0]      PRL      = 9'(PULSE_RESPONSE_LENGTH);
   localparam logic [8:0]      LAST_TAP = 9'(PULSE_RESPONSE_LENGTH - 1);
   localparam logic [TW-1:0]   T_LAST   = TW'(TIMEOUT_CYCLES - 1);

   logic [2:0]    state;
   logic [2:0]    next_state;
   logic [8:0]    cnt;
   logic [TW-1:0] tcnt;
   logic [7:0]    base;
   logic [31:0]   coef [PULSE_RESPONSE_LENGTH];
   logic [8:0]    cap_sel;
   logic [8:0]    tap_sel;
   logic [31:0]   coef_sel;
   logic          accept;
   logic [31:0]   unused_hi;

   assign unused_hi = mem_rd_data[63:32];
   assign accept    = start && (state == S_IDLE || state == S_RUN || state == S_ERR);

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE, S_RUN, S_ERR: if (start) next_state = S_DRST;
         S_DRST:  if (cnt == 9'd1) next_state = S_FETCH;
         S_FETCH: if (cnt == PRL) next_state = S_LOAD;
         S_LOAD:  if (cnt == PRL + 9'd1) next_state = S_WAIT;
         S_WAIT: begin
            if (dfe_done_wait) next_state = S_RUN;
            else if (tcnt == T_LAST) next_state = S_ERR;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // Status flags and the DFE reset are registered from next_state so they line up with state.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state               <= S_IDLE;
         cnt                 <= '0;
         tcnt                <= '0;
         base                <= '0;
         dfe_rstn            <= 1'b0;
         busy                <= 1'b0;
         configured          <= 1'b0;
         error               <= 1'b0;
         dfe_signal_in       <= '0;
         dfe_signal_in_valid <= 1'b0;
      end else begin
         state      <= next_state;
         cnt        <= (next_state != state) ? 9'd0 : cnt + 9'd1;
         tcnt       <= (state == S_WAIT && !dfe_done_wait) ? tcnt + TW'(1) : '0;
         if (accept) base <= cfg_base;
         dfe_rstn   <= !(next_state inside {S_IDLE, S_DRST, S_ERR});
         busy       <= next_state inside {S_DRST, S_FETCH, S_LOAD, S_WAIT};
         configured <= (next_state == S_RUN);
         error      <= (next_state == S_ERR);
         if (up_ready) begin
            dfe_signal_in       <= up_data;
            dfe_signal_in_valid <= up_valid;
         end else begin
            dfe_signal_in_valid <= 1'b0;
         end
      end
   end

   // Read data arrives one cycle after the strobe, so FETCH cycle k captures word k-1.
   assign cap_sel = cnt - 9'd1;

   always_ff @(posedge clk) begin
      if (state == S_FETCH && cnt != 9'd0) begin
         for (int i = 0; i < PULSE_RESPONSE_LENGTH; i++) begin
            if (cap_sel == 9'(i)) coef[i] <= mem_rd_data[31:0];
         end
      end
   end

   always_comb begin
      tap_sel = (cnt == 9'd0) ? 9'd0 : cnt - 9'd1;
      if (tap_sel > LAST_TAP) tap_sel = LAST_TAP;
      coef_sel = '0;
      for (int i = 0; i < PULSE_RESPONSE_LENGTH; i++) begin
         if (tap_sel == 9'(i)) coef_sel = coef[i];
      end
   end

   assign mem_rd_en    = (state == S_FETCH) && (cnt < PRL);
   assign mem_rd_addr  = mem_rd_en ? base + cnt[7:0] : 8'd0;
   assign dfe_load_mem = (state == S_LOAD);
   assign dfe_location = dfe_load_mem ? ((cnt > LAST_TAP) ? LAST_TAP[7:0] : cnt[7:0]) : 8'd0;
   assign dfe_mem_data = dfe_load_mem ? {32'd0, coef_sel} : 64'd0;
   assign up_ready     = (state == S_RUN) && !start;

endmodule

// File: tb/tb_dfe_tap_loader.sv
// Self-checking bench for dfe_tap_loader with a coefficient memory model and a
// behavioural DFE tap-array model.
module tb_dfe_tap_loader;

   localparam int PRL = 5;
   localparam int SR  = 8;
   localparam int TO  = 64;

   logic                 clk = 1'b0;
   logic                 rstn = 1'b1;
   logic                 start = 1'b0;
   logic [7:0]           cfg_base = '0;
   logic                 mem_rd_en;
   logic [7:0]           mem_rd_addr;
   logic [63:0]          mem_rd_data = '0;
   logic                 dfe_rstn;
   logic                 dfe_load_mem;
   logic [7:0]           dfe_location;
   logic [63:0]          dfe_mem_data;
   logic                 dfe_done_wait = 1'b0;
   logic signed [SR-1:0] up_data = '0;
   logic                 up_valid = 1'b0;
   logic                 up_ready;
   logic signed [SR-1:0] dfe_signal_in;
   logic                 dfe_signal_in_valid;
   logic                 busy;
   logic                 configured;
   logic                 error;

   int checks = 0;
   int errors = 0;

   dfe_tap_loader #(
      .PULSE_RESPONSE_LENGTH(PRL),
      .SIGNAL_RESOLUTION(SR),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .cfg_base(cfg_base),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .dfe_rstn(dfe_rstn), .dfe_load_mem(dfe_load_mem), .dfe_location(dfe_location),
      .dfe_mem_data(dfe_mem_data), .dfe_done_wait(dfe_done_wait),
      .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
      .dfe_signal_in(dfe_signal_in), .dfe_signal_in_valid(dfe_signal_in_valid),
      .busy(busy), .configured(configured), .error(error)
   );

   always #5 clk = ~clk;

   // Coefficient memory: one-cycle registered read.
   logic [63:0] mem [256];
   always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

   // DFE model: writes the tap at the previous cycle's location, counts load cycles and
   // raises done_wait two cycles after the last load cycle when healthy.
   bit          healthy = 1'b1;
   logic [31:0] taps [PRL];
   logic [7:0]  prev_loc = '0;
   int          load_cnt = 0;
   logic        done_d1 = 1'b0;
   always @(posedge clk) begin
      if (!dfe_rstn) begin
         load_cnt      <= 0;
         done_d1       <= 1'b0;
         dfe_done_wait <= 1'b0;
         prev_loc      <= '0;
      end else begin
         prev_loc <= dfe_location;
         if (dfe_load_mem) begin
            for (int i = 0; i < PRL; i++) if (int'(prev_loc) == i) taps[i] <= dfe_mem_data[31:0];
            load_cnt <= load_cnt + 1;
         end
         done_d1       <= healthy && (load_cnt >= PRL + 2);
         dfe_done_wait <= done_d1;
      end
   end

   // Observations collected while a configuration sequence runs (t = edges since start).
   int         obs_rstn_low, obs_first_load, obs_cfg_t, obs_err_t;
   bit         obs_valid_seen, obs_excl_bad, obs_busy_gap;
   logic [7:0] obs_addr [$];
   logic [7:0] obs_loc [$];
   logic [63:0] obs_ldata [$];

   task automatic fill_mem();
      for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};
   endtask

   task automatic run_sequence(input logic [7:0] b, input bit drive_valid, input int restart_t, input int max_t);
      obs_rstn_low = 0; obs_first_load = -1; obs_cfg_t = -1; obs_err_t = -1;
      obs_valid_seen = 0; obs_excl_bad = 0; obs_busy_gap = 0;
      obs_addr.delete(); obs_loc.delete(); obs_ldata.delete();
      @(negedge clk);
      start = 1'b1; cfg_base = b; up_valid = drive_valid; up_data = 8'sh5A;
      for (int t = 0; t < max_t; t++) begin
         @(negedge clk);
         start = 1'b0; up_valid = 1'b0;
         if (int'(busy) + int'(configured) + int'(error) > 1) obs_excl_bad = 1;
         if (dfe_signal_in_valid) obs_valid_seen = 1;
         if (configured) begin obs_cfg_t = t; break; end
         if (error) begin obs_err_t = t; break; end
         if (!busy) obs_busy_gap = 1;
         if (!dfe_rstn) obs_rstn_low++;
         if (mem_rd_en) obs_addr.push_back(mem_rd_addr);
         if (dfe_load_mem) begin
            if (obs_first_load < 0) obs_first_load = t;
            obs_loc.push_back(dfe_location);
            obs_ldata.push_back(dfe_mem_data);
         end
         if (t == restart_t) begin start = 1'b1; cfg_base = ~b; end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1 rstn = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_rd_en, mem_rd_addr, dfe_rstn, dfe_load_mem, dfe_location, dfe_mem_data, up_ready,
              dfe_signal_in, dfe_signal_in_valid, busy, configured, error} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rd_en=%b addr=%h drstn=%b load=%b loc=%h data=%h rdy=%b sig=%h v=%b busy=%b cfg=%b err=%b, required all 0",
                     mem_rd_en, mem_rd_addr, dfe_rstn, dfe_load_mem, dfe_location, dfe_mem_data, up_ready,
                     dfe_signal_in, dfe_signal_in_valid, busy, configured, error);
         end
         start = 1'($urandom); cfg_base = 8'($urandom); up_data = SR'($urandom); up_valid = 1'($urandom);
      end
      start = 1'b0; up_valid = 1'b1;
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({up_ready, configured, busy, dfe_rstn} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got rdy/cfg/busy/drstn=%b, required 0000",
                     {up_ready, configured, busy, dfe_rstn});
         end
      end
      up_valid = 1'b0;
   endtask

   task automatic test_nominal();
      logic [7:0] b;
      b = 8'h10;
      for (int k = 0; k < PRL; k++) mem[8'(b + k)] = {$urandom, 32'h0003_0002 + 32'(k)};
      healthy = 1'b1;
      run_sequence(b, 1'b0, -1, 200);
      checks++;
      if (obs_rstn_low !== 2) begin errors++; $display("[TB] FAIL nominal_drst_len: got %0d required 2", obs_rstn_low); end
      checks++;
      if (obs_addr.size() !== PRL) begin errors++; $display("[TB] FAIL nominal_read_count: got %0d required %0d", obs_addr.size(), PRL); end
      for (int k = 0; k < PRL && k < obs_addr.size(); k++) begin
         checks++;
         if (obs_addr[k] !== 8'(b + k)) begin errors++; $display("[TB] FAIL nominal_read_addr[%0d]: got %h required %h", k, obs_addr[k], 8'(b + k)); end
      end
      checks++;
      if (obs_first_load !== PRL + 3) begin errors++; $display("[TB] FAIL nominal_first_load: got %0d required %0d", obs_first_load, PRL + 3); end
      checks++;
      if (obs_loc.size() !== PRL + 2) begin errors++; $display("[TB] FAIL nominal_load_count: got %0d required %0d", obs_loc.size(), PRL + 2); end
      for (int j = 0; j < PRL + 2 && j < obs_loc.size(); j++) begin
         int exp_loc;
         int idx;
         logic [63:0] exp_data;
         exp_loc  = (j < PRL - 1) ? j : PRL - 1;
         idx      = (j == 0) ? 0 : ((j - 1 < PRL - 1) ? j - 1 : PRL - 1);
         exp_data = {32'd0, mem[8'(b + idx)][31:0]};
         checks++;
         if (obs_loc[j] !== 8'(exp_loc)) begin errors++; $display("[TB] FAIL nominal_location[%0d]: got %0d required %0d", j, obs_loc[j], exp_loc); end
         checks++;
         if (obs_ldata[j] !== exp_data) begin errors++; $display("[TB] FAIL nominal_mem_data[%0d]: got %h required %h", j, obs_ldata[j], exp_data); end
      end
      checks++;
      if (obs_cfg_t !== 2 * PRL + 8) begin errors++; $display("[TB] FAIL nominal_cfg_time: got %0d required %0d", obs_cfg_t, 2 * PRL + 8); end
      checks++;
      if ({obs_excl_bad, obs_busy_gap, obs_valid_seen} !== 3'b000) begin
         errors++; $display("[TB] FAIL nominal_flags: got excl/busygap/valid=%b required 000", {obs_excl_bad, obs_busy_gap, obs_valid_seen});
      end
      for (int k = 0; k < PRL; k++) begin
         checks++;
         if (taps[k] !== mem[8'(b + k)][31:0]) begin errors++; $display("[TB] FAIL nominal_tap[%0d]: got %h required %h", k, taps[k], mem[8'(b + k)][31:0]); end
      end
      checks++;
      if ({up_ready, dfe_rstn, busy} !== 3'b110) begin errors++; $display("[TB] FAIL nominal_run_state: got rdy/drstn/busy=%b required 110", {up_ready, dfe_rstn, busy}); end
   endtask

   task automatic test_passthrough();
      logic signed [SR-1:0] exp_d;
      logic                 exp_v;
      exp_d = '0; exp_v = 1'b0;
      for (int i = 0; i < 31; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++;
            if (dfe_signal_in !== exp_d) begin errors++; $display("[TB] FAIL pass_data[%0d]: got %0d required %0d", i, dfe_signal_in, exp_d); end
            checks++;
            if (dfe_signal_in_valid !== exp_v) begin errors++; $display("[TB] FAIL pass_valid[%0d]: got %b required %b", i, dfe_signal_in_valid, exp_v); end
         end
         checks++;
         if (up_ready !== 1'b1) begin errors++; $display("[TB] FAIL pass_ready[%0d]: got %b required 1", i, up_ready); end
         if (i == 0) begin up_data = -8'sd5; up_valid = 1'b1; end
         else if (i == 1) begin up_data = SR'($urandom); up_valid = 1'b0; end
         else begin up_data = SR'($urandom); up_valid = 1'($urandom); end
         exp_d = up_data; exp_v = up_valid;
      end
      up_valid = 1'b0;
   endtask

   task automatic test_timeout();
      logic [7:0] b;
      healthy = 1'b0;
      b = 8'($urandom);
      run_sequence(b, 1'b0, -1, 300);
      checks++;
      if (obs_err_t !== (PRL + 3) + (PRL + 2) + TO) begin errors++; $display("[TB] FAIL timeout_time: got %0d required %0d", obs_err_t, (PRL + 3) + (PRL + 2) + TO); end
      checks++;
      if (obs_cfg_t !== -1) begin errors++; $display("[TB] FAIL timeout_no_cfg: got %0d required -1", obs_cfg_t); end
      for (int i = 0; i < 4; i++) begin
         up_data = SR'($urandom); up_valid = 1'b1;
         @(negedge clk);
         checks++;
         if ({error, up_ready, dfe_signal_in_valid, dfe_rstn, busy, configured} !== 6'b100000) begin
            errors++; $display("[TB] FAIL err_hold[%0d]: got err/rdy/v/drstn/busy/cfg=%b required 100000", i,
                               {error, up_ready, dfe_signal_in_valid, dfe_rstn, busy, configured});
         end
      end
      up_valid = 1'b0;
      healthy = 1'b1;
      b = 8'($urandom);
      run_sequence(b, 1'b0, -1, 200);
      checks++;
      if (obs_cfg_t !== 2 * PRL + 8) begin errors++; $display("[TB] FAIL recover_cfg_time: got %0d required %0d", obs_cfg_t, 2 * PRL + 8); end
      checks++;
      if (obs_rstn_low !== 2) begin errors++; $display("[TB] FAIL recover_drst_len: got %0d required 2", obs_rstn_low); end
      for (int k = 0; k < PRL; k++) begin
         checks++;
         if (taps[k] !== mem[8'(b + k)][31:0]) begin errors++; $display("[TB] FAIL recover_tap[%0d]: got %h required %h", k, taps[k], mem[8'(b + k)][31:0]); end
      end
   endtask

   task automatic test_reconfig();
      logic [7:0] b;
      b = 8'($urandom);
      run_sequence(b, 1'b1, PRL + 4, 200);
      checks++;
      if (obs_valid_seen !== 1'b0) begin errors++; $display("[TB] FAIL reconfig_sample_dropped: got valid seen=%b required 0", obs_valid_seen); end
      checks++;
      if (obs_rstn_low !== 2) begin errors++; $display("[TB] FAIL reconfig_drst_len: got %0d required 2", obs_rstn_low); end
      checks++;
      if (obs_cfg_t !== 2 * PRL + 8) begin errors++; $display("[TB] FAIL reconfig_cfg_time: got %0d required %0d", obs_cfg_t, 2 * PRL + 8); end
      checks++;
      if (obs_loc.size() !== PRL + 2) begin errors++; $display("[TB] FAIL reconfig_load_count: got %0d required %0d", obs_loc.size(), PRL + 2); end
      for (int k = 0; k < PRL; k++) begin
         checks++;
         if (taps[k] !== mem[8'(b + k)][31:0]) begin errors++; $display("[TB] FAIL reconfig_tap[%0d]: got %h required %h", k, taps[k], mem[8'(b + k)][31:0]); end
      end
   endtask

   task automatic test_wrap();
      logic [7:0] exp_addr [$];
      exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
      run_sequence(8'hFE, 1'b0, -1, 200);
      checks++;
      if (obs_addr.size() !== PRL) begin errors++; $display("[TB] FAIL wrap_read_count: got %0d required %0d", obs_addr.size(), PRL); end
      for (int k = 0; k < PRL && k < obs_addr.size(); k++) begin
         checks++;
         if (obs_addr[k] !== exp_addr[k]) begin errors++; $display("[TB] FAIL wrap_addr[%0d]: got %h required %h", k, obs_addr[k], exp_addr[k]); end
         checks++;
         if (taps[k] !== mem[exp_addr[k]][31:0]) begin errors++; $display("[TB] FAIL wrap_tap[%0d]: got %h required %h", k, taps[k], mem[exp_addr[k]][31:0]); end
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      start = 1'b1; cfg_base = 8'($urandom);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++;
      if ({busy, dfe_rstn, mem_rd_en, configured} !== 4'b0000) begin
         errors++; $display("[TB] FAIL mid_reset: got busy/drstn/rd_en/cfg=%b required 0000", {busy, dfe_rstn, mem_rd_en, configured});
      end
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, up_ready, dfe_rstn} !== 3'b000) begin
         errors++; $display("[TB] FAIL mid_reset_idle: got busy/rdy/drstn=%b required 000", {busy, up_ready, dfe_rstn});
      end
   endtask

   initial begin
      fill_mem();
      test_reset();
      test_nominal();
      test_passthrough();
      test_timeout();
      test_reconfig();
      test_wrap();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation still running after 2 ms, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
